// File: rtl/hamming_secded_decoder.sv
// Pipelined extended-Hamming (SECDED) decoder with valid/ready flow control.
// Stage 1 registers the received codeword, stage 2 registers the decode
// result. Corrected / uncorrectable words are tallied in saturating counters.
module hamming_secded_decoder #(
  parameter  int DATA_W = 4,
  parameter  int CNT_W  = 8,
  // Check-bit count: smallest r with 2^r >= DATA_W + r + 1.
  localparam int R      = $clog2(DATA_W + $clog2(DATA_W + 1) + 1),
  localparam int N      = DATA_W + R + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_codeword,
  input  logic              correct_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [R-1:0]      out_syndrome,
  output logic              out_corrected,
  output logic              out_uncorrectable,
  input  logic              clear_counts,
  output logic [CNT_W-1:0]  corr_count,
  output logic [CNT_W-1:0]  uncorr_count
);

  // Hamming position of data bit k: the k-th non-power-of-two index >= 1.
  function automatic int data_pos(input int k);
    int seen;
    int pos;
    seen = 0;
    pos  = 0;
    for (int i = 1; i < 2 * (DATA_W + R + 1); i++) begin
      if ((i & (i - 1)) != 0) begin
        if (seen == k) begin
          pos = i;
          break;
        end
        seen++;
      end
    end
    return pos;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic              vld_p1;
  logic [N-1:0]      cw_p1;
  logic              cen_p1;

  logic              vld_p2;
  logic [DATA_W-1:0] data_p2;
  logic [R-1:0]      syn_p2;
  logic              corr_p2;
  logic              uncorr_p2;

  logic [CNT_W-1:0]  corr_cnt;
  logic [CNT_W-1:0]  uncorr_cnt;

  logic              s1_load;
  logic              s2_load;

  logic [R-1:0]      syn_c;
  logic              par_c;
  logic              single_pos_c;
  logic              corr_c;
  logic              uncorr_c;
  logic [N-1:0]      cw_fix_c;
  logic [DATA_W-1:0] data_c;

  // A stage may load when it is empty or its content moves on this cycle.
  assign s2_load  = !vld_p2 || out_ready;
  assign s1_load  = !vld_p1 || s2_load;
  assign in_ready = s1_load;

  // ---- stage 1: capture codeword and correction mode ----
  // Stage-1 valid flag advances whenever the stage can load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (s1_load) begin
      vld_p1 <= in_valid;
    end
  end

  // Stage-1 payload only changes on an accepted input word.
  always_ff @(posedge clk) begin
    if (s1_load && in_valid) begin
      cw_p1  <= in_codeword;
      cen_p1 <= correct_en;
    end
  end

  // Syndrome, overall parity, error classification and optional repair.
  always_comb begin
    syn_c = '0;
    for (int i = 1; i < N; i++) begin
      if (cw_p1[i]) syn_c = syn_c ^ R'(i);
    end
    par_c        = ^cw_p1;
    single_pos_c = (syn_c != '0) && (int'(syn_c) <= N - 1);
    corr_c       = par_c && ((syn_c == '0) || single_pos_c);
    uncorr_c     = (syn_c != '0) && !(par_c && single_pos_c);
    cw_fix_c     = cw_p1;
    if (par_c && single_pos_c && cen_p1) begin
      cw_fix_c = cw_p1 ^ (N'(1) << syn_c);
    end
  end

  for (genvar k = 0; k < DATA_W; k++) begin : g_extract
    localparam int P = data_pos(k);
    assign data_c[k] = cw_fix_c[P];
  end

  // ---- stage 2: capture decode result ----
  // Result register; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2    <= 1'b0;
      data_p2   <= '0;
      syn_p2    <= '0;
      corr_p2   <= 1'b0;
      uncorr_p2 <= 1'b0;
    end else if (s2_load) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2   <= data_c;
        syn_p2    <= syn_c;
        corr_p2   <= corr_c;
        uncorr_p2 <= uncorr_c;
      end
    end
  end

  // Error statistics, counted on output handshake; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (clear_counts) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (vld_p2 && out_ready) begin
      if (corr_p2)   corr_cnt   <= sat_inc(corr_cnt);
      if (uncorr_p2) uncorr_cnt <= sat_inc(uncorr_cnt);
    end
  end

  assign out_valid         = vld_p2;
  assign out_data          = data_p2;
  assign out_syndrome      = syn_p2;
  assign out_corrected     = corr_p2;
  assign out_uncorrectable = uncorr_p2;
  assign corr_count        = corr_cnt;
  assign uncorr_count      = uncorr_cnt;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Scoreboard bench for hamming_secded_decoder (DATA_W=4, CNT_W=2).
module tb_hamming_secded_decoder;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 2;
  localparam int R      = 3;
  localparam int N      = 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [R-1:0]      syn;
    logic              corr;
    logic              uncorr;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N-1:0]      in_codeword = '0;
  logic              correct_en = 1'b1;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic [R-1:0]      out_syndrome;
  logic              out_corrected;
  logic              out_uncorrectable;
  logic              clear_counts = 1'b0;
  logic [CNT_W-1:0]  corr_count;
  logic [CNT_W-1:0]  uncorr_count;

  int   n_cmp = 0;
  int   n_err = 0;
  bit   rand_ready = 1'b0;
  exp_t sb_q[$];

  hamming_secded_decoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_codeword(in_codeword),
    .correct_en(correct_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_syndrome(out_syndrome), .out_corrected(out_corrected),
    .out_uncorrectable(out_uncorrectable),
    .clear_counts(clear_counts), .corr_count(corr_count), .uncorr_count(uncorr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input int d, input int s, input int c, input int u);
    exp_t e;
    e.data   = DATA_W'(d);
    e.syn    = R'(s);
    e.corr   = (c != 0);
    e.uncorr = (u != 0);
    return e;
  endfunction

  // Reference decode written from the code's definition: positions whose
  // bits are set are XOR-ed into a syndrome, data lives at non-powers-of-two.
  function automatic exp_t ref_decode(input logic [N-1:0] cw, input logic cen);
    exp_t         e;
    int           s;
    int           p;
    int           dpos[$];
    logic [N-1:0] fixed;
    s = 0;
    p = 0;
    for (int i = 0; i < N; i++) if (cw[i]) begin p ^= 1; s ^= i; end
    for (int i = 1; i < N; i++) if ((i & (i - 1)) != 0) dpos.push_back(i);
    fixed    = cw;
    e.corr   = 1'b0;
    e.uncorr = 1'b0;
    if (p == 1 && s == 0) e.corr = 1'b1;
    else if (p == 1 && s < N) begin
      e.corr = 1'b1;
      if (cen) fixed[s] = ~fixed[s];
    end else if (s != 0) e.uncorr = 1'b1;
    for (int k = 0; k < DATA_W; k++) e.data[k] = fixed[dpos[k]];
    e.syn = R'(s);
    return e;
  endfunction

  // Build a valid codeword: data at non-power positions, check bits chosen
  // so the syndrome is zero, then overall parity makes the total XOR zero.
  function automatic logic [N-1:0] encode(input logic [DATA_W-1:0] d);
    logic [N-1:0] cw;
    int           k;
    int           s;
    cw = '0;
    k  = 0;
    s  = 0;
    for (int i = 1; i < N; i++) begin
      if ((i & (i - 1)) != 0) begin
        cw[i] = d[k];
        k++;
        if (cw[i]) s ^= i;
      end
    end
    for (int j = 0; j < R; j++) cw[1 << j] = ((s >> j) & 1) != 0;
    cw[0] = ^cw[N-1:1];
    return cw;
  endfunction

  task automatic send(input logic [N-1:0] cw, input logic cen, input exp_t e);
    int   cyc;
    logic ok;
    cyc         = 0;
    ok          = 1'b0;
    in_valid    = 1'b1;
    in_codeword = cw;
    correct_en  = cen;
    while (!ok && cyc < 200) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      ok = in_ready;
      if (ok) sb_q.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    int cyc;
    cyc       = 0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    @(posedge clk);
    #1;
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic pulse_clear();
    clear_counts = 1'b1;
    @(posedge clk);
    #1;
    clear_counts = 1'b0;
  endtask

  // Monitor: compares each output handshake against the scoreboard, checks
  // stall stability and tracks the expected counter values.
  initial begin
    logic [CNT_W-1:0] m_corr;
    logic [CNT_W-1:0] m_uncorr;
    logic [8:0]       held;
    logic             held_v;
    exp_t             e;
    m_corr   = '0;
    m_uncorr = '0;
    held     = '0;
    held_v   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        m_corr   = '0;
        m_uncorr = '0;
        held_v   = 1'b0;
      end else begin
        chk("corr_count", 32'(corr_count), 32'(m_corr));
        chk("uncorr_count", 32'(uncorr_count), 32'(m_uncorr));
        if (held_v) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_hold", 32'({out_data, out_syndrome, out_corrected, out_uncorrectable}),
              32'(held));
        end
        held_v = out_valid && !out_ready;
        held   = {out_data, out_syndrome, out_corrected, out_uncorrectable};
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_output", 32'(out_valid), 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("out_data", 32'(out_data), 32'(e.data));
            chk("out_syndrome", 32'(out_syndrome), 32'(e.syn));
            chk("out_corrected", 32'(out_corrected), 32'(e.corr));
            chk("out_uncorrectable", 32'(out_uncorrectable), 32'(e.uncorr));
            if (e.corr && m_corr != '1) m_corr = m_corr + 1'b1;
            if (e.uncorr && m_uncorr != '1) m_uncorr = m_uncorr + 1'b1;
          end
        end
        if (clear_counts) begin
          m_corr   = '0;
          m_uncorr = '0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] cw;
    logic         cen;
    int           p1;
    int           p2;
    int           nf;
    int           cyc;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_flags", 32'({out_syndrome, out_corrected, out_uncorrectable}), 32'd0);
    chk("reset_counts", 32'({corr_count, uncorr_count}), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Clean word with latency check.
    send(8'hAA, 1'b1, mk(4'hB, 0, 0, 0));
    chk("latency_cycle1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("latency_cycle2", 32'(out_valid), 32'd1);
    drain();

    // Single error, corrected then detect-only.
    send(8'h8A, 1'b1, mk(4'hB, 5, 1, 0));
    drain();
    chk("corr_count_after_single", 32'(corr_count), 32'd1);
    send(8'h8A, 1'b0, mk(4'h9, 5, 1, 0));
    send(8'hAB, 1'b1, mk(4'hB, 0, 1, 0));
    send(8'hCA, 1'b1, mk(4'hD, 3, 0, 1));
    drain();
    chk("uncorr_count_after_double", 32'(uncorr_count), 32'd1);
    pulse_clear();
    chk("counts_cleared", 32'({corr_count, uncorr_count}), 32'd0);

    // Backpressure: consumer stalls while three words are offered.
    out_ready = 1'b0;
    send(8'hAA, 1'b1, mk(4'hB, 0, 0, 0));
    send(8'h8A, 1'b1, mk(4'hB, 5, 1, 0));
    in_valid    = 1'b1;
    in_codeword = 8'hCA;
    @(negedge clk);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_in_ready_low2", 32'(in_ready), 32'd0);
    chk("bp_head_data", 32'({out_valid, out_data}), 32'h1B);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'hCA, 1'b1, mk(4'hD, 3, 0, 1));
    drain();
    pulse_clear();

    // Saturation of the 2-bit corrected counter.
    repeat (5) send(8'h8A, 1'b1, mk(4'hB, 5, 1, 0));
    drain();
    chk("corr_saturated", 32'(corr_count), 32'd3);

    // Clear coinciding with a corrected handshake.
    out_ready = 1'b0;
    send(8'h8A, 1'b1, mk(4'hB, 5, 1, 0));
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("clear_setup_valid", 32'(out_valid), 32'd1);
    clear_counts = 1'b1;
    out_ready    = 1'b1;
    @(posedge clk);
    #1;
    clear_counts = 1'b0;
    chk("clear_beats_increment", 32'(corr_count), 32'd0);
    drain();

    // Randomized traffic with random backpressure and 0/1/2 bit errors.
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      cw  = encode(DATA_W'($urandom));
      nf  = $urandom_range(0, 2);
      p1  = $urandom_range(0, N - 1);
      p2  = (p1 + $urandom_range(1, N - 1)) % N;
      if (nf >= 1) cw[p1] = ~cw[p1];
      if (nf == 2) cw[p2] = ~cw[p2];
      cen = 1'($urandom_range(0, 1));
      send(cw, cen, ref_decode(cw, cen));
      if ($urandom_range(0, 3) == 0) begin
        out_ready = ($urandom_range(0, 1) != 0);
        @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    drain();

    // Reset with words in flight: output vanishes and nothing stale follows.
    send(8'hAA, 1'b1, mk(4'hB, 0, 0, 0));
    send(8'h8A, 1'b1, mk(4'hB, 5, 1, 0));
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("reset_async_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_no_stale", 32'(out_valid), 32'd0);
    chk("post_reset_counts", 32'({corr_count, uncorr_count}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
